// File: rtl/rs_dec_share_sched.sv
// rs_dec_share_sched: one RS(7,5) GF(2^3) decoder time-shared between
// NUM_REQ codeword requesters through a round-robin arbiter and a two-stage
// valid/ready pipeline.
//
// Optional feature: define RS_DEC_ERR_CNT_EN to build the saturating
// corrected-word counter on err_cnt (cleared by err_clr). Without it err_cnt
// is tied to zero and err_clr is ignored.
//
// Code definition: field polynomial x^3+x+1; codeword c(x) = sum c_i x^i with
// symbol i at bits [3i+2:3i]; roots alpha^0 and alpha^1; symbols 0..1 are
// parity, symbols 2..6 carry the 15-bit message (message = word[20:6]).

// Single-error RS(7,5) decoder, combinational, message symbols only.
module rs_decoder_N7K5 (
  input  logic [20:0] rxWord,
  output logic [14:0] msg,
  output logic [2:0]  errVal
);

  // GF(8) multiply, polynomial basis, reduction by x^3 = x + 1
  function automatic logic [2:0] gfMul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    logic [2:0] t;
    p = 3'b000;
    t = a;
    for (int k = 0; k < 3; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[1:0], 1'b0} ^ (t[2] ? 3'b011 : 3'b000);
    end
    return p;
  endfunction

  // alpha^i for the symbol positions
  function automatic logic [2:0] gfExp(input int unsigned i);
    case (i)
      0:       return 3'd1;
      1:       return 3'd2;
      2:       return 3'd4;
      3:       return 3'd3;
      4:       return 3'd6;
      5:       return 3'd7;
      default: return 3'd5;
    endcase
  endfunction

  // discrete log base alpha; log(0) is never used
  function automatic logic [2:0] gfLog(input logic [2:0] v);
    case (v)
      3'd1:    return 3'd0;
      3'd2:    return 3'd1;
      3'd4:    return 3'd2;
      3'd3:    return 3'd3;
      3'd6:    return 3'd4;
      3'd7:    return 3'd5;
      3'd5:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] syn0;
  logic [2:0] syn1;
  logic [2:0] log0;
  logic [2:0] log1;
  logic [2:0] errLoc;
  logic       fixEn;

  // syndromes, error location and in-place correction of message symbols
  always_comb begin
    syn0   = 3'b000;
    syn1   = 3'b000;
    log0   = 3'b000;
    log1   = 3'b000;
    errLoc = 3'b000;
    fixEn  = 1'b0;
    msg    = rxWord[20:6];
    for (int i = 0; i < 7; i++) begin
      syn0 = syn0 ^ rxWord[i*3 +: 3];
      syn1 = syn1 ^ gfMul(rxWord[i*3 +: 3], gfExp(i));
    end
    if ((syn0 != 3'b000) && (syn1 != 3'b000)) begin
      fixEn = 1'b1;
      log0  = gfLog(syn0);
      log1  = gfLog(syn1);
      // (log1 - log0) mod 7 using 3-bit wraparound
      if (log1 >= log0) errLoc = log1 - log0;
      else              errLoc = log1 - log0 - 3'd1;
    end
    for (int i = 2; i < 7; i++) begin
      if (fixEn && (errLoc == 3'(i))) msg[(i-2)*3 +: 3] = rxWord[i*3 +: 3] ^ syn0;
    end
    errVal = syn0;
  end

endmodule

module rs_dec_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*21-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [14:0]           dec_data,
  output logic [TAG_W-1:0]      dec_tag,
  output logic                  dec_corr,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  err_clr
);

  localparam int unsigned CW_W  = 21;
  localparam int unsigned MSG_W = 15;

  logic [TAG_W-1:0]   rrPtr;
  logic [NUM_REQ-1:0] hiMask;
  logic [NUM_REQ-1:0] pickVec;
  logic [NUM_REQ-1:0] grantOh;
  logic [TAG_W-1:0]   grantIdx;
  logic [CW_W-1:0]    grantData;
  logic               grantAny;
  logic               s1Valid;
  logic [CW_W-1:0]    s1Data;
  logic [TAG_W-1:0]   s1Tag;
  logic               s1Free;
  logic               s2Load;
  logic               accept;
  logic [MSG_W-1:0]   decMsg;
  logic [2:0]         decErr;

  // round-robin pick: lowest requester above rrPtr, else lowest overall
  always_comb begin
    hiMask    = '0;
    grantOh   = '0;
    grantIdx  = '0;
    grantData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hiMask[i] = (TAG_W'(i) > rrPtr);
    end
    pickVec  = (|(req_valid & hiMask)) ? (req_valid & hiMask) : req_valid;
    grantAny = |req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pickVec[i]) begin
        grantOh   = NUM_REQ'(1) << i;
        grantIdx  = TAG_W'(i);
        grantData = req_data[i*CW_W +: CW_W];
      end
    end
  end

  assign s2Load    = s1Valid & (~dec_valid | dec_ready);
  assign s1Free    = ~s1Valid | s2Load;
  assign accept    = grantAny & s1Free;
  // held low during reset so no requester sees a strobe that cannot land
  assign req_ready = rstN ? (grantOh & {NUM_REQ{s1Free}}) : '0;

  // S1 input register and round-robin pointer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
      s1Tag   <= '0;
      rrPtr   <= TAG_W'(NUM_REQ - 1);
    end else if (accept) begin
      s1Valid <= 1'b1;
      s1Data  <= grantData;
      s1Tag   <= grantIdx;
      rrPtr   <= grantIdx;
    end else if (s2Load) begin
      s1Valid <= 1'b0;
    end
  end

  rs_decoder_N7K5 uDec (
    .rxWord (s1Data),
    .msg    (decMsg),
    .errVal (decErr)
  );

  // S2 output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dec_valid <= 1'b0;
      dec_data  <= '0;
      dec_tag   <= '0;
      dec_corr  <= 1'b0;
    end else if (s2Load) begin
      dec_valid <= 1'b1;
      dec_data  <= decMsg;
      dec_tag   <= s1Tag;
      dec_corr  <= |decErr;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

`ifdef RS_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] errCnt;

  // saturating count of corrected words handed to the consumer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      errCnt <= '0;
    end else if (err_clr) begin
      errCnt <= '0;
    end else if (dec_valid && dec_ready && dec_corr && (errCnt != {CNT_W{1'b1}})) begin
      errCnt <= errCnt + CNT_W'(1);
    end
  end

  assign err_cnt = errCnt;
`else
  logic unusedErrClr;
  assign unusedErrClr = err_clr;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_rs_dec_share_sched.sv
// Directed bench for rs_dec_share_sched: a cycle model of the handshakes and
// a scoreboard of expected results, checked with immediate assertions.
module tb_rs_dec_share_sched;

  localparam int NR = 4;
  localparam int TW = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [14:0]   data;
    logic          corr;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstN;
  logic [NR-1:0]  rv;
  logic [NR*21-1:0] rd;
  logic [NR-1:0]  req_ready;
  logic           dec_valid;
  logic           dr;
  logic [14:0]    dec_data;
  logic [TW-1:0]  dec_tag;
  logic           dec_corr;
  logic [CW-1:0]  err_cnt;
  logic           clr;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [14:0] reqMsg[NR];
  logic        reqCorr[NR];
  int          left[NR];
  int          errMode;
  logic        mS1, mOut;
  int          mRr, mCnt;

  always #5 clk = ~clk;

  rs_dec_share_sched #(.NUM_REQ(NR), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .req_valid (rv),
    .req_data  (rd),
    .req_ready (req_ready),
    .dec_valid (dec_valid),
    .dec_ready (dr),
    .dec_data  (dec_data),
    .dec_tag   (dec_tag),
    .dec_corr  (dec_corr),
    .err_cnt   (err_cnt),
    .err_clr   (clr)
  );

  // multiply by alpha in GF(8), x^3+x+1, as a lookup
  function automatic logic [2:0] mulA(input logic [2:0] a);
    case (a)
      3'd1: return 3'd2;
      3'd2: return 3'd4;
      3'd4: return 3'd3;
      3'd3: return 3'd6;
      3'd6: return 3'd7;
      3'd7: return 3'd5;
      3'd5: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // systematic encoder by search: the parity pair that zeroes r(1) and r(alpha)
  function automatic logic [20:0] encode(input logic [14:0] msg);
    logic [20:0] cw;
    logic [2:0]  s0, s1;
    for (int p = 0; p < 64; p++) begin
      cw = {msg, 6'(p)};
      s0 = 3'd0;
      s1 = 3'd0;
      for (int i = 6; i >= 0; i--) begin
        s0 = s0 ^ cw[i*3 +: 3];
        s1 = mulA(s1) ^ cw[i*3 +: 3];
      end
      if (s0 == 3'd0 && s1 == 3'd0) return cw;
    end
    return 21'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic newWord(input int i);
    logic [14:0] msg;
    logic [20:0] cw;
    int          sym;
    msg = 15'($urandom);
    cw  = encode(msg);
    reqCorr[i] = 1'b0;
    if (errMode != 0) begin
      sym = $urandom_range(0, 6);
      cw[sym*3 +: 3] = cw[sym*3 +: 3] ^ 3'($urandom_range(1, 7));
      reqCorr[i] = 1'b1;
    end
    reqMsg[i] = msg;
    rd[i*21 +: 21] = cw;
  endtask

  task automatic load(input int i, input int n);
    left[i] = n;
    if (n > 0) newWord(i);
    rv[i] = (n > 0);
  endtask

  task automatic modelReset();
    mS1 = 1'b0;
    mOut = 1'b0;
    mRr = NR - 1;
    mCnt = 0;
    expQ.delete();
  endtask

  // one clock: check from the model, then advance the model across the edge
  task automatic step();
    logic s2load, s1free, pop, acc;
    int   gi, j;
    logic [NR-1:0] expRdy;
    #1;
    s2load = mS1 & (~mOut | dr);
    s1free = ~mS1 | s2load;
    gi = -1;
    for (int k = 1; k <= NR; k++) begin
      j = (mRr + k) % NR;
      if (gi < 0 && rv[j]) gi = j;
    end
    acc = (gi >= 0) && s1free;
    expRdy = acc ? NR'(1) << gi : '0;
    chk("req_ready", 32'(req_ready), 32'(expRdy));
    chk("dec_valid", 32'(dec_valid), 32'(mOut));
    chk("err_cnt", 32'(err_cnt), 32'(mCnt));
    if (mOut) begin
      if (expQ.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        chk("dec_data", 32'(dec_data), 32'(expQ[0].data));
        chk("dec_tag", 32'(dec_tag), 32'(expQ[0].tag));
        chk("dec_corr", 32'(dec_corr), 32'(expQ[0].corr));
      end
    end
    pop = mOut & dr;
    @(posedge clk);
    @(negedge clk);
`ifdef RS_DEC_ERR_CNT_EN
    if (clr) mCnt = 0;
    else if (pop && expQ.size() != 0 && expQ[0].corr && mCnt < CNT_MAX) mCnt++;
`endif
    if (pop && expQ.size() != 0) void'(expQ.pop_front());
    mOut = s2load ? 1'b1 : (dr ? 1'b0 : mOut);
    mS1  = acc ? 1'b1 : (s2load ? 1'b0 : mS1);
    if (acc) begin
      expQ.push_back('{tag: TW'(gi), data: reqMsg[gi], corr: reqCorr[gi]});
      mRr = gi;
      left[gi]--;
      if (left[gi] > 0) newWord(gi);
      else rv[gi] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (rv != '0 || expQ.size() != 0 || mS1 || mOut); n++) step();
    chk("drain_queue", 32'(expQ.size()), 32'(0));
    chk("drain_req", 32'(rv), 32'(0));
  endtask

  initial begin
    logic [20:0] cw;
    rstN = 1'b0; rv = '0; rd = '0; dr = 1'b1; clr = 1'b0; errMode = 0;
    for (int i = 0; i < NR; i++) begin left[i] = 0; reqMsg[i] = '0; reqCorr[i] = 1'b0; end
    modelReset();
    #12;
    chk("rst_dec_valid", 32'(dec_valid), 32'(0));
    chk("rst_dec_data", 32'(dec_data), 32'(0));
    chk("rst_dec_tag", 32'(dec_tag), 32'(0));
    chk("rst_dec_corr", 32'(dec_corr), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rstN = 1'b1;

    // T1: clean codeword from requester 0
    cw = encode(15'h1234);
    rd[20:0] = cw; reqMsg[0] = 15'h1234; reqCorr[0] = 1'b0; left[0] = 1; rv[0] = 1'b1;
    step();
    step();
    #1;
    chk("t1_valid", 32'(dec_valid), 32'(1));
    chk("t1_data", 32'(dec_data), 32'h1234);
    chk("t1_tag", 32'(dec_tag), 32'(0));
    chk("t1_corr", 32'(dec_corr), 32'(0));
    drain();

    // T2: symbol 3 corrupted on requester 2
    cw = encode(15'h1234);
    cw[11:9] = cw[11:9] ^ 3'b101;
    rd[2*21 +: 21] = cw; reqMsg[2] = 15'h1234; reqCorr[2] = 1'b1; left[2] = 1; rv[2] = 1'b1;
    step();
    step();
    #1;
    chk("t2_data", 32'(dec_data), 32'h1234);
    chk("t2_tag", 32'(dec_tag), 32'(2));
    chk("t2_corr", 32'(dec_corr), 32'(1));
    drain();

    // T3: all requesters busy, clean words, full throughput
    errMode = 0;
    for (int i = 0; i < NR; i++) load(i, 12);
    drain();

    // T4: back-pressure with single-symbol errors anywhere in the word
    errMode = 1;
    for (int i = 0; i < NR; i++) load(i, 10);
    dr = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("t4_s1_full", 32'(req_ready), 32'(0));
    dr = 1'b1;
    drain();

    // T5: asynchronous reset with both stages full
    errMode = 0;
    for (int i = 0; i < NR; i++) load(i, 6);
    dr = 1'b0;
    for (int n = 0; n < 3; n++) step();
    #2 rstN = 1'b0;
    #1;
    chk("t5_dec_valid", 32'(dec_valid), 32'(0));
    chk("t5_req_ready", 32'(req_ready), 32'(0));
    chk("t5_dec_data", 32'(dec_data), 32'(0));
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    dr = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'(1));
    drain();

    // T6: corrected-word counter saturation and clear priority
    errMode = 1;
    load(1, 20);
    drain();
`ifdef RS_DEC_ERR_CNT_EN
    chk("t6_saturated", 32'(err_cnt), 32'(CNT_MAX));
`else
    chk("t6_tied_zero", 32'(err_cnt), 32'(0));
`endif
    load(1, 1);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("t6_clear", 32'(err_cnt), 32'(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
